// File: rtl/ixu_pkg.sv
// IXU decode shared types: opcode enum, instruction field positions, register index type.
package ixu_pkg;

    typedef enum logic [3:0] {
        IXU_OP_NOP = 4'h0,
        IXU_OP_ADD = 4'h1,
        IXU_OP_SUB = 4'h2,
        IXU_OP_AND = 4'h3,
        IXU_OP_OR  = 4'h4,
        IXU_OP_XOR = 4'h5,
        IXU_OP_SLL = 4'h6,
        IXU_OP_SRL = 4'h7
    } ixu_op_e;

    typedef logic [4:0] reg_idx_t;

    localparam int unsigned OP_LSB     = 0;
    localparam int unsigned OP_W       = 4;
    localparam int unsigned IS_IMM_BIT = 4;
    localparam int unsigned RD_LSB     = 5;
    localparam int unsigned RS1_LSB    = 10;
    localparam int unsigned RS2_LSB    = 15;
    localparam int unsigned IMM_LSB    = 20;
    localparam int unsigned IMM_W      = 12;
    localparam int unsigned REG_W      = 5;

    function automatic ixu_op_e get_op(input logic [31:0] instr);
        return ixu_op_e'(instr[OP_LSB +: OP_W]);
    endfunction

    function automatic reg_idx_t get_reg(input logic [31:0] instr, input int unsigned lsb);
        return instr[lsb +: REG_W];
    endfunction

endpackage

// File: rtl/ixu_scoreboard.sv
// Register busy scoreboard: one bit per architectural register, x0 never busy.
// A set and a clear of the same register in one cycle leaves it busy.
import ixu_pkg::*;

module ixu_scoreboard (
    input  logic        clk,
    input  logic        rst,
    input  logic        set_en,
    input  reg_idx_t    set_idx,
    input  logic        clr_en,
    input  reg_idx_t    clr_idx,
    output logic [31:0] busy
);

    logic [31:0] busy_q, busy_d;

    // Next busy vector: clear first so a same-cycle set overrides it.
    always_comb begin
        busy_d = busy_q;
        if (clr_en && (clr_idx != '0)) begin
            busy_d[clr_idx] = 1'b0;
        end
        if (set_en && (set_idx != '0)) begin
            busy_d[set_idx] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Busy register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/ixu_decode.sv
// IXU slot decoder: one-entry instruction buffer, RAW/WAW hazard check against the
// busy scoreboard, and a bubble (is_nop_out=1, fields zero) whenever nothing issues.
// Optional: define IXU_DECODE_WB_BYPASS_EN to let a same-cycle writeback unblock issue.
import ixu_pkg::*;

module ixu_decode (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid_in,
    input  logic [31:0] instr_in,
    output logic        instr_ready_out,
    input  logic        ex_stall_in,
    input  logic        flush_in,
    input  logic        wb_valid_in,
    input  logic [4:0]  wb_rd_in,
    output logic [3:0]  op_out,
    output logic        is_nop_out,
    output logic        is_imm_type_out,
    output logic [4:0]  rs1_out,
    output logic [4:0]  rs2_out,
    output logic [4:0]  rd_out,
    output logic [11:0] imm_out
);

    logic        buf_v_q;
    logic [31:0] buf_instr_q;

    ixu_op_e     buf_op;
    reg_idx_t    buf_rd, buf_rs1, buf_rs2;
    logic        buf_is_imm, buf_is_nop;
    logic [11:0] buf_imm;

    logic [31:0] busy, busy_eff;
    logic        hazard, issue, accept;

    assign buf_op     = get_op(buf_instr_q);
    assign buf_is_imm = buf_instr_q[IS_IMM_BIT];
    assign buf_rd     = get_reg(buf_instr_q, RD_LSB);
    assign buf_rs1    = get_reg(buf_instr_q, RS1_LSB);
    assign buf_rs2    = get_reg(buf_instr_q, RS2_LSB);
    assign buf_imm    = buf_instr_q[IMM_LSB +: IMM_W];
    assign buf_is_nop = (buf_op == IXU_OP_NOP);

    // Busy view used by the hazard check, optionally bypassing this cycle's writeback.
    always_comb begin
        busy_eff = busy;
`ifdef IXU_DECODE_WB_BYPASS_EN
        if (wb_valid_in) begin
            busy_eff[wb_rd_in] = 1'b0;
        end
`else
        busy_eff[0] = 1'b0;
`endif
    end

    // Hazard, issue and handshake; reset forces a bubble and an open ready.
    always_comb begin
        hazard = buf_v_q && !buf_is_nop &&
                 (busy_eff[buf_rs1] || (!buf_is_imm && busy_eff[buf_rs2]) || busy_eff[buf_rd]);
        issue           = buf_v_q && !hazard && !ex_stall_in && !rst;
        instr_ready_out = !flush_in && (rst || !buf_v_q || issue);
        accept          = instr_valid_in && instr_ready_out;
    end

    // ID/EX outputs: decoded fields on issue, otherwise an all-zero bubble.
    always_comb begin
        op_out          = '0;
        is_nop_out      = 1'b1;
        is_imm_type_out = 1'b0;
        rs1_out         = '0;
        rs2_out         = '0;
        rd_out          = '0;
        imm_out         = '0;
        if (issue) begin
            op_out          = buf_op;
            is_nop_out      = buf_is_nop;
            is_imm_type_out = buf_is_imm;
            rs1_out         = buf_rs1;
            rs2_out         = buf_rs2;
            rd_out          = buf_rd;
            imm_out         = buf_imm;
        end
    end

    // Buffer update: reset, then flush, then accept, then issue drains it.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_v_q     <= 1'b0;
            buf_instr_q <= '0;
        end else if (flush_in) begin
            buf_v_q <= 1'b0;
        end else if (accept) begin
            buf_v_q     <= 1'b1;
            buf_instr_q <= instr_in;
        end else if (issue) begin
            buf_v_q <= 1'b0;
        end
    end

    ixu_scoreboard u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .set_en  (issue && !buf_is_nop),
        .set_idx (buf_rd),
        .clr_en  (wb_valid_in),
        .clr_idx (wb_rd_in),
        .busy    (busy)
    );

endmodule

// File: tb/tb_ixu_decode.sv
// Self-checking bench for ixu_decode: directed scenarios followed by random traffic,
// all compared against a cycle-level behavioural model of the decoder.
module tb_ixu_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid_in;
    logic [31:0] instr_in;
    logic        instr_ready_out;
    logic        ex_stall_in;
    logic        flush_in;
    logic        wb_valid_in;
    logic [4:0]  wb_rd_in;
    logic [3:0]  op_out;
    logic        is_nop_out;
    logic        is_imm_type_out;
    logic [4:0]  rs1_out, rs2_out, rd_out;
    logic [11:0] imm_out;

    always #5 clk = ~clk;

    ixu_decode dut (
        .clk             (clk),
        .rst             (rst),
        .instr_valid_in  (instr_valid_in),
        .instr_in        (instr_in),
        .instr_ready_out (instr_ready_out),
        .ex_stall_in     (ex_stall_in),
        .flush_in        (flush_in),
        .wb_valid_in     (wb_valid_in),
        .wb_rd_in        (wb_rd_in),
        .op_out          (op_out),
        .is_nop_out      (is_nop_out),
        .is_imm_type_out (is_imm_type_out),
        .rs1_out         (rs1_out),
        .rs2_out         (rs2_out),
        .rd_out          (rd_out),
        .imm_out         (imm_out)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state.
    bit          m_busy [32];
    bit          m_v;
    int unsigned m_instr;

    // Last sampled DUT outputs, for directed checks.
    logic        obs_ready, obs_nop, obs_imm_t;
    logic [4:0]  obs_rd;
    logic [11:0] obs_imm;

    function automatic int unsigned fld(input int unsigned w, input int unsigned lsb,
                                        input int unsigned width);
        return (w / (32'd1 << lsb)) % (32'd1 << width);
    endfunction

    function automatic logic [31:0] mk(input int unsigned op, input int unsigned imm_t,
                                       input int unsigned rd, input int unsigned rs1,
                                       input int unsigned rs2, input int unsigned imm);
        return op + imm_t * 16 + rd * 32 + rs1 * 1024 + rs2 * 32768 + imm * 1048576;
    endfunction

    function automatic bit reg_busy(input int unsigned r, input bit wbv, input int unsigned wbr);
        if (r == 0) return 1'b0;
`ifdef IXU_DECODE_WB_BYPASS_EN
        if (wbv && wbr == r) return 1'b0;
`endif
        return m_busy[r];
    endfunction

    // One clock: drive at negedge, compare mid-cycle, advance model at posedge.
    task automatic cycle(input bit r, input bit v, input logic [31:0] ins, input bit st,
                         input bit fl, input bit wbv, input logic [4:0] wbr);
        int unsigned op, imm_t, rd, rs1, rs2, imm;
        bit haz, iss, exp_ready;
        logic [32:0] exp_outs;
        @(negedge clk);
        rst = r; instr_valid_in = v; instr_in = ins; ex_stall_in = st;
        flush_in = fl; wb_valid_in = wbv; wb_rd_in = wbr;
        #1;
        op    = fld(m_instr, 0, 4);
        imm_t = fld(m_instr, 4, 1);
        rd    = fld(m_instr, 5, 5);
        rs1   = fld(m_instr, 10, 5);
        rs2   = fld(m_instr, 15, 5);
        imm   = fld(m_instr, 20, 12);
        haz = m_v && op != 0 && (reg_busy(rs1, wbv, wbr) ||
              (imm_t == 0 && reg_busy(rs2, wbv, wbr)) || reg_busy(rd, wbv, wbr));
        iss = !r && m_v && !haz && !st;
        exp_ready = !fl && (r || !m_v || iss);
        if (iss) exp_outs = {op == 0, imm_t[0], op[3:0], rs1[4:0], rs2[4:0], rd[4:0], imm[11:0]};
        else     exp_outs = {1'b1, 32'd0};
        check("ready", 64'(instr_ready_out), 64'(exp_ready));
        check("outs", 64'({is_nop_out, is_imm_type_out, op_out, rs1_out, rs2_out, rd_out,
                           imm_out}), 64'(exp_outs));
        obs_ready = instr_ready_out; obs_nop = is_nop_out; obs_imm_t = is_imm_type_out;
        obs_rd = rd_out; obs_imm = imm_out;
        @(posedge clk);
        if (r) begin
            m_v = 1'b0;
            foreach (m_busy[i]) m_busy[i] = 1'b0;
        end else begin
            if (wbv && wbr != 0) m_busy[wbr] = 1'b0;
            if (iss && op != 0 && rd != 0) m_busy[rd] = 1'b1;
            if (fl) m_v = 1'b0;
            else if (v && exp_ready) begin
                m_v = 1'b1;
                m_instr = ins;
            end else if (iss) m_v = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 32'd0, 0, 0, 0, 5'd0);
    endtask

    initial begin
        logic [31:0] ri;
        int unsigned wr;
        m_v = 1'b0;
        m_instr = 0;
        foreach (m_busy[i]) m_busy[i] = 1'b0;

        // Reset, with a buffered instruction offered during it.
        cycle(1, 0, 32'd0, 0, 0, 0, 5'd0);
        cycle(1, 1, mk(1, 0, 9, 0, 0, 0), 0, 0, 0, 5'd0);
        check("rst_nop", 64'(obs_nop), 64'd1);
        check("rst_ready", 64'(obs_ready), 64'd1);
        idle(1);
        check("post_rst_nop", 64'(obs_nop), 64'd1);

        // ADD rd=3 rs1=1 rs2=2 issues one cycle after acceptance.
        cycle(0, 1, mk(1, 0, 3, 1, 2, 0), 0, 0, 0, 5'd0);
        idle(1);
        check("add_issue", 64'(obs_nop), 64'd0);
        check("add_rd", 64'(obs_rd), 64'd3);

        // SUB rs1=3 holds behind ADD until writeback of r3.
        cycle(0, 1, mk(2, 0, 4, 3, 0, 0), 0, 0, 0, 5'd0);
        idle(1);
        check("raw_bubble", 64'(obs_nop), 64'd1);
        check("raw_not_ready", 64'(obs_ready), 64'd0);
        idle(1);
        cycle(0, 0, 32'd0, 0, 0, 1, 5'd3);
`ifdef IXU_DECODE_WB_BYPASS_EN
        check("raw_wb_cycle", 64'(obs_nop), 64'd0);
        idle(1);
        check("raw_after_wb", 64'(obs_nop), 64'd1);
`else
        check("raw_wb_cycle", 64'(obs_nop), 64'd1);
        idle(1);
        check("raw_after_wb", 64'(obs_nop), 64'd0);
`endif

        // Immediate op ignores a busy rs2.
        cycle(0, 1, mk(1, 0, 5, 0, 0, 0), 0, 0, 0, 5'd0);
        idle(1);
        cycle(0, 1, mk(3, 1, 6, 0, 5, 12'hABC), 0, 0, 0, 5'd0);
        idle(1);
        check("imm_issue", 64'(obs_nop), 64'd0);
        check("imm_val", 64'(obs_imm), 64'hABC);
        check("imm_type", 64'(obs_imm_t), 64'd1);

        // Three stall cycles hold the buffer; issue when stall drops.
        cycle(0, 1, mk(4, 0, 8, 0, 0, 0), 0, 0, 0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 32'd0, 1, 0, 0, 5'd0);
            check("stall_bubble", 64'(obs_nop), 64'd1);
        end
        idle(1);
        check("stall_release", 64'(obs_rd), 64'd8);

        // Flush during a RAW hold on r8; busy bit survives the flush.
        cycle(0, 1, mk(5, 0, 10, 8, 0, 0), 0, 0, 0, 5'd0);
        idle(1);
        cycle(0, 0, 32'd0, 0, 1, 0, 5'd0);
        check("flush_ready", 64'(obs_ready), 64'd0);
        idle(1);
        check("post_flush_ready", 64'(obs_ready), 64'd1);
        cycle(0, 1, mk(5, 0, 10, 8, 0, 0), 0, 0, 0, 5'd0);
        idle(1);
        check("busy_kept", 64'(obs_nop), 64'd1);
        cycle(0, 0, 32'd0, 0, 0, 1, 5'd8);
        idle(2);

        // Issue of rd=7 together with writeback of r7 leaves r7 busy.
        cycle(0, 1, mk(6, 0, 7, 0, 0, 0), 0, 0, 0, 5'd0);
        cycle(0, 0, 32'd0, 0, 0, 1, 5'd7);
        cycle(0, 1, mk(7, 0, 11, 7, 0, 0), 0, 0, 0, 5'd0);
        idle(1);
        check("set_wins", 64'(obs_nop), 64'd1);
        cycle(0, 0, 32'd0, 0, 0, 1, 5'd7);
        idle(2);

        // Random traffic over a small register window to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            ri = mk(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15),
                    $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 7), $urandom_range(0, 4095));
            wr = $urandom_range(0, 7);
            cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 60, ri,
                  $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 5,
                  $urandom_range(0, 99) < 40, wr[4:0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ixu_decode.md
IXU_DECODE -- requirements
Module: ixu_decode

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  input  1  reset; synchronous, active-high.
REQ-003 instr_valid_in  input  1  fetch offers an IXU slot instruction.
REQ-004 instr_in  input  32  raw IXU slot instruction.
REQ-005 instr_ready_out  output  1  decoder accepts instr_in this cycle.
REQ-006 ex_stall_in  input  1  downstream stall; same signal that holds the ID/EX register.
REQ-007 flush_in  input  1  discard the buffered, not-yet-issued instruction.
REQ-008 wb_valid_in, wb_rd_in  input  1, 5  writeback completion; clears the busy bit of wb_rd_in.
REQ-009 op_out, is_nop_out, is_imm_type_out  output  4, 1, 1  decoded fields to ID/EX.
REQ-010 rs1_out, rs2_out, rd_out, imm_out  output  5, 5, 5, 12  decoded fields to ID/EX.

Function
REQ-011 Field map: op=[3:0], is_imm=[4], rd=[9:5], rs1=[14:10], rs2=[19:15], imm=[31:20]; op 4'h0 is NOP.
REQ-012 One-entry buffer (buf_v, buf_instr); accepted when instr_valid_in && instr_ready_out.
REQ-013 instr_ready_out = !flush_in && (!buf_v || issue), combinational.
REQ-014 hazard = buffered non-NOP with busy[rs1], or busy[rs2] when !is_imm, or busy[rd] (WAW); x0 is never busy.
REQ-015 issue = buf_v && !hazard && !ex_stall_in.
REQ-016 Issuing: is_nop_out=0; all other outputs are the decoded buffer fields; latency from acceptance to issue is 1 cycle when no hazard or stall.
REQ-017 Not issuing: is_nop_out=1; op_out, rs1_out, rs2_out, rd_out, imm_out, is_imm_type_out all 0, so a bubble enters ID/EX.
REQ-018 Buffered NOP: issues with is_nop_out=1 and sets no busy bit.
REQ-019 Issue of a non-NOP with rd!=0 sets busy[rd] at the clock edge.
REQ-020 wb_valid_in clears busy[wb_rd_in] at the clock edge; wb_rd_in=0 is ignored.
REQ-021 Set and clear of the same register in one cycle: the set wins.
REQ-022 Buffer update priority: flush_in clears buf_v; otherwise an accept loads the buffer; otherwise an issue clears buf_v; otherwise the buffer holds.
REQ-023 flush_in does not alter the scoreboard, because in-flight writebacks still arrive.
REQ-024 With ex_stall_in high: no issue, no scoreboard set, and the buffer holds.

Reset
REQ-025 rst clears buf_v and all 32 busy bits.
REQ-026 During and after rst: is_nop_out=1, other outputs 0, instr_ready_out=1 when flush_in=0.
REQ-027 rst asserted mid-hazard discards the buffered instruction; no issue follows.

Configuration
REQ-028 Macro IXU_DECODE_WB_BYPASS_EN defined: hazard evaluates busy with the same-cycle wb_valid_in/wb_rd_in bit masked off, so a dependent instruction issues in the writeback cycle.
REQ-029 Macro IXU_DECODE_WB_BYPASS_EN undefined: hazard uses registered busy only, so issue occurs 1 cycle after writeback.

Structure
REQ-030 Package ixu_pkg holds the opcode typedef (enum logic [3:0]), IXU_OP_NOP, field bit-position localparams, and the register-index typedef.
REQ-031 Sub-module ixu_scoreboard holds the busy vector with set/clear/query ports; ixu_decode instantiates it once.

Verification
REQ-032 Reset, then ADD rd=3 rs1=1 rs2=2 offered -> issues the next cycle with is_nop_out=0, rd_out=3; busy[3]=1.
REQ-033 ADD rd=3 followed by SUB rs1=3 -> SUB holds with bubbles (is_nop_out=1, instr_ready_out=0) until wb_rd_in=3; with the macro it issues in the writeback cycle, without the macro 1 cycle later.
REQ-034 Immediate op with is_imm=1, rs2=5, busy[5]=1 -> no hazard; issues with imm_out=12'hABC.
REQ-035 ex_stall_in high 3 cycles with a valid buffer -> no issue, buffer held, busy unchanged; issues the cycle stall drops.
REQ-036 flush_in during a RAW hold -> buf_v=0, busy bits retained, instr_ready_out=0 that cycle and 1 the next.
REQ-037 Same-cycle issue of rd=7 and writeback of rd=7 -> busy[7]=1 afterward.
